oled_spi_writer: RTL and testbench
==================================

# oled_spi_writer

Byte-level SPI transmitter that sits directly downstream of the OLED initialisation sequencer and, later, the frame-data path. It accepts one byte plus a command/data flag per handshake and shifts it to the panel MSB-first in SPI mode 0. It drives chip-select, D/C and serial clock, then reports completion with a one-cycle done pulse.

## Interface
- CLK_DIV, 4: CLK cycles per SCLK half-period; legal range 1..255.
- CLK  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- WRITE_START  input  1  transfer request; level, held by upstream until WRITE_DONE is seen.
- DATA  input  8  byte to send; sampled with WRITE_START.
- DC_IN  input  1  0 = command byte, 1 = display data; sampled with WRITE_START.
- WRITE_DONE  output  1  one-cycle pulse, byte fully sent and CS released.
- BUSY  output  1  high from acceptance until the WAIT_RELEASE exit.
- OLED_SCLK  output  1  serial clock; idle low.
- OLED_MOSI  output  1  serial data.
- OLED_CS_N  output  1  chip select, active-low.
- OLED_DC  output  1  panel D/C line.

## Operation
- All outputs registered. Reset values: OLED_CS_N=1, OLED_SCLK=0, OLED_MOSI=0, OLED_DC=0, WRITE_DONE=0, BUSY=0. The state is IDLE, the bit counter is 7 and the divider is 0.
- States: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, DONE, WAIT_RELEASE.
- IDLE: if WRITE_START=1, latch DATA into the shift register and DC_IN into OLED_DC. Drive CS_N=0, MOSI=DATA[7], BUSY=1, then go to SETUP.
- SETUP: CLK_DIV cycles with SCLK low, then go to SCLK_HI.
- SCLK_HI: SCLK=1 for CLK_DIV cycles; the panel samples MOSI on the rising edge. Then go to SCLK_LO.
- SCLK_LO: SCLK=0 for CLK_DIV cycles. On entry, if bits remain, shift left and drive the next bit onto MOSI. After the 8th low phase go to HOLD; otherwise go back to SCLK_HI.
- HOLD: CS_N=1 and MOSI=0 for CLK_DIV cycles. OLED_DC keeps its value. Then go to DONE.
- DONE: WRITE_DONE=1 for exactly one cycle, then go to WAIT_RELEASE.
- WAIT_RELEASE: stay until WRITE_START=0, then go to IDLE with BUSY=0. This prevents a second send of the same byte while upstream is still dropping its request.
- DATA and DC_IN changes after acceptance are ignored until the next IDLE acceptance.
- RST_N low at any point, including mid-byte, returns immediately to the reset values. No partial completion pulse is generated.
- The divider counter is sized by $clog2(CLK_DIV+1). Its terminal count is CLK_DIV-1. CLK_DIV=1 gives SCLK = CLK/2.

## Timing
- Let E0 be the edge on which IDLE samples WRITE_START=1.
- CS_N falls and MOSI = bit7 after E0.
- The first SCLK rise is at E0+CLK_DIV. Bit k (7..0) rises at E0+(2(7−k)+1)·CLK_DIV.
- The last SCLK fall is at E0+16·CLK_DIV. CS_N rises at E0+17·CLK_DIV.
- WRITE_DONE is high for the single cycle after edge E0+18·CLK_DIV. That is 72 cycles at the default.
- The earliest next acceptance is the 2nd edge after WRITE_START is seen low in WAIT_RELEASE.
- Back-to-back throughput with the init sequencer's drop/raise behaviour is 18·CLK_DIV+3 cycles per byte.
- MOSI is stable for at least CLK_DIV cycles before and after each SCLK rising edge.

## Structure
- Shared package oled_pkg:
  - state enum (oled_spi_state_t);
  - default CLK_DIV constant;
  - command byte constants used by the sequencer (display off 8'hAE, display on 8'hAF).
- One sub-module, oled_spi_tick: a divider counter with enable, synchronous clear and a terminal-count pulse. It is instantiated once to time every phase.
- The shift register, bit counter and FSM live in oled_spi_writer.

## Test plan
- Reset then idle, no request: CS_N=1, SCLK=0, MOSI=0, DC=0, WRITE_DONE=0, BUSY=0, held for 100 cycles.
- DATA=8'hAE, DC_IN=0, default CLK_DIV, start held until done:
  - the bench SPI monitor captures 0xAE with DC=0 on 8 SCLK rises;
  - WRITE_DONE pulses once, 72 cycles after acceptance.
- DATA=8'hA5, DC_IN=1, CLK_DIV=1:
  - SCLK period is 2 cycles and 0xA5 is captured with DC=1;
  - WRITE_DONE is 18 cycles after acceptance.
- WRITE_START held high 20 cycles after WRITE_DONE: no second transfer and no extra SCLK edges. Dropping start, then raising it with 8'hAF, yields exactly one 0xAF transfer.
- DATA toggled every cycle during transfer of 8'h3C: the captured byte is still 0x3C.
- RST_N pulsed low after the 3rd SCLK rise:
  - outputs are at reset values immediately and WRITE_DONE never pulses;
  - a following transfer of 8'h81 completes correctly.

Source files
------------

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_pkg
// Description : Shared types and constants for the OLED SPI path: writer
//               state encoding, default SCLK divider and sequencer commands.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

  // Writer FSM states
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SETUP        = 3'd1,
    ST_SCLK_HI      = 3'd2,
    ST_SCLK_LO      = 3'd3,
    ST_HOLD         = 3'd4,
    ST_DONE         = 3'd5,
    ST_WAIT_RELEASE = 3'd6
  } oled_spi_state_t;

  // CLK cycles per SCLK half-period
  localparam int unsigned C_CLK_DIV_DEFAULT = 4;

  // Command bytes issued by the init sequencer
  localparam logic [7:0] C_CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] C_CMD_DISPLAY_ON  = 8'hAF;

endpackage
`default_nettype wire

// File: rtl/oled_spi_tick.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_tick
// Description : Phase-length divider. Counts enabled cycles and flags the
//               last cycle of each CLK_DIV-long phase, then self-restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  input  logic CLR,
  output logic TC
);

  localparam int unsigned    CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  C_TERM = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Terminal count is only meaningful while the phase is running
  assign TC = EN && (r_cnt == C_TERM);

  // Phase counter: clear wins, otherwise count and wrap at terminal count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (CLR) begin
      r_cnt <= '0;
    end else if (EN) begin
      r_cnt <= TC ? '0 : (r_cnt + C_ONE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_spi_writer.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_writer
// Description : Byte-wide SPI mode-0 transmitter for the OLED panel. Accepts
//               one byte + D/C flag per level handshake, shifts it MSB-first,
//               releases CS and pulses WRITE_DONE for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_writer
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = C_CLK_DIV_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WRITE_START,
  input  logic [7:0] DATA,
  input  logic       DC_IN,
  output logic       WRITE_DONE,
  output logic       BUSY,
  output logic       OLED_SCLK,
  output logic       OLED_MOSI,
  output logic       OLED_CS_N,
  output logic       OLED_DC
);

  oled_spi_state_t r_state;
  // Only the bits still to be sent after bit 7 are kept; bit 7 goes
  // straight from DATA onto MOSI at acceptance.
  logic [6:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            w_phase_en;
  logic            w_tc;

  // Every state except the handshake states is a timed phase
  assign w_phase_en = (r_state == ST_SETUP)   || (r_state == ST_SCLK_HI) ||
                      (r_state == ST_SCLK_LO) || (r_state == ST_HOLD);

  oled_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (w_phase_en),
    .CLR   (!w_phase_en),
    .TC    (w_tc)
  );

  // Transfer FSM with registered panel-side and handshake outputs.
  // The bit counter names the bit currently on MOSI; it is decremented on
  // each new SCLK rise, so a fall with count 0 is the final low phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= 3'd7;
      WRITE_DONE <= 1'b0;
      BUSY       <= 1'b0;
      OLED_SCLK  <= 1'b0;
      OLED_MOSI  <= 1'b0;
      OLED_CS_N  <= 1'b1;
      OLED_DC    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (WRITE_START) begin
            r_shift   <= DATA[6:0];
            r_bit_cnt <= 3'd7;
            OLED_DC   <= DC_IN;
            OLED_CS_N <= 1'b0;
            OLED_MOSI <= DATA[7];
            BUSY      <= 1'b1;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tc) begin
            OLED_SCLK <= 1'b1;
            r_state   <= ST_SCLK_HI;
          end
        end
        ST_SCLK_HI: begin
          if (w_tc) begin
            OLED_SCLK <= 1'b0;
            r_state   <= ST_SCLK_LO;
            if (r_bit_cnt != 3'd0) begin
              OLED_MOSI <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
            end
          end
        end
        ST_SCLK_LO: begin
          if (w_tc) begin
            if (r_bit_cnt == 3'd0) begin
              OLED_CS_N <= 1'b1;
              OLED_MOSI <= 1'b0;
              r_state   <= ST_HOLD;
            end else begin
              OLED_SCLK <= 1'b1;
              r_bit_cnt <= r_bit_cnt - 3'd1;
              r_state   <= ST_SCLK_HI;
            end
          end
        end
        ST_HOLD: begin
          if (w_tc) begin
            WRITE_DONE <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          WRITE_DONE <= 1'b0;
          r_state    <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          // Upstream holds its request until it sees done; wait for the drop
          // so the same byte is never sent twice.
          if (!WRITE_START) begin
            BUSY      <= 1'b0;
            r_bit_cnt <= 3'd7;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_spi_writer
// Description : Self-checking bench for oled_spi_writer. Instance 0 uses the
//               default divider (4), instance 1 uses CLK_DIV=1. An SPI
//               monitor per instance captures MOSI on SCLK rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_spi_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       dc_in;
  logic [1:0] start;
  wire  [1:0] done, busy, sclk, mosi, csn, odc;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap   [2] = '{8'h00, 8'h00};
  int         rises [2] = '{0, 0};
  int         dones [2] = '{0, 0};
  time        last_r[2] = '{0, 0};
  time        per   [2] = '{0, 0};

  always #5 clk = ~clk;

  oled_spi_writer #(.CLK_DIV(4)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .WRITE_START(start[0]), .DATA(data), .DC_IN(dc_in),
    .WRITE_DONE(done[0]), .BUSY(busy[0]), .OLED_SCLK(sclk[0]), .OLED_MOSI(mosi[0]),
    .OLED_CS_N(csn[0]), .OLED_DC(odc[0])
  );

  oled_spi_writer #(.CLK_DIV(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .WRITE_START(start[1]), .DATA(data), .DC_IN(dc_in),
    .WRITE_DONE(done[1]), .BUSY(busy[1]), .OLED_SCLK(sclk[1]), .OLED_MOSI(mosi[1]),
    .OLED_CS_N(csn[1]), .OLED_DC(odc[1])
  );

  // SPI monitors: panel samples MOSI on SCLK rise
  always @(posedge sclk[0]) begin
    cap[0] = {cap[0][6:0], mosi[0]};
    rises[0]++;
    per[0] = $time - last_r[0];
    last_r[0] = $time;
  end
  always @(posedge sclk[1]) begin
    cap[1] = {cap[1][6:0], mosi[1]};
    rises[1]++;
    per[1] = $time - last_r[1];
    last_r[1] = $time;
  end

  // Done-pulse counters
  always @(negedge clk) begin
    if (done[0] === 1'b1) dones[0]++;
    if (done[1] === 1'b1) dones[1]++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       dc;
    bit         toggle;
    int         hold;
    logic [7:0] exp_byte;
    int         exp_lat;
    int         exp_per;
  } vec_t;

  task automatic xfer(input vec_t v);
    int r0;
    int d0;
    int lat;
    @(negedge clk);
    data = v.data;
    dc_in = v.dc;
    start[v.sel] = 1'b1;
    r0 = rises[v.sel];
    d0 = dones[v.sel];
    @(posedge clk); #1;
    chk("cs_fall",  32'(csn[v.sel]),  32'd0);
    chk("busy_acc", 32'(busy[v.sel]), 32'd1);
    chk("mosi_b7",  32'(mosi[v.sel]), 32'(v.data[7]));
    lat = 0;
    while (done[v.sel] !== 1'b1 && lat < 4000) begin
      @(posedge clk); #1;
      lat++;
      if (v.toggle) data = ~data;
    end
    chk("done_latency", 32'(lat), 32'(v.exp_lat));
    chk("sclk_rises",   32'(rises[v.sel] - r0), 32'd8);
    chk("byte",         32'(cap[v.sel]), 32'(v.exp_byte));
    chk("dc_line",      32'(odc[v.sel]), 32'(v.dc));
    chk("cs_released",  32'(csn[v.sel]), 32'd1);
    chk("sclk_period",  32'(per[v.sel]), 32'(v.exp_per));
    @(posedge clk); #1;
    chk("done_width", 32'(done[v.sel]), 32'd0);
    repeat (v.hold) @(posedge clk);
    #1;
    if (v.hold > 0) begin
      chk("hold_no_rises", 32'(rises[v.sel] - r0), 32'd8);
      chk("hold_busy",     32'(busy[v.sel]), 32'd1);
      chk("hold_cs",       32'(csn[v.sel]), 32'd1);
    end
    @(negedge clk);
    start[v.sel] = 1'b0;
    data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_release", 32'(busy[v.sel]), 32'd0);
    chk("done_count",   32'(dones[v.sel] - d0), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int bad;
    int r0;
    int d0;
    int wait_cnt;
    vec_t v81;

    vecs[0] = '{0, 8'hAE, 1'b0, 1'b0, 0,  8'hAE, 72, 80};
    vecs[1] = '{1, 8'hA5, 1'b1, 1'b0, 0,  8'hA5, 18, 20};
    vecs[2] = '{0, 8'h3C, 1'b0, 1'b1, 0,  8'h3C, 72, 80};
    vecs[3] = '{0, 8'hAE, 1'b1, 1'b0, 20, 8'hAE, 72, 80};
    vecs[4] = '{0, 8'hAF, 1'b0, 1'b0, 0,  8'hAF, 72, 80};

    rst_n = 1'b0;
    start = 2'b00;
    data  = 8'h00;
    dc_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no request for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (csn !== 2'b11 || sclk !== 2'b00 || mosi !== 2'b00 || odc !== 2'b00 ||
          done !== 2'b00 || busy !== 2'b00) bad++;
    end
    chk("idle_outputs_100", 32'(bad), 32'd0);
    chk("idle_cs_n", 32'(csn), 32'h3);
    chk("idle_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 5; i++) xfer(vecs[i]);

    // Reset pulse after the 3rd SCLK rise of a transfer
    @(negedge clk);
    data = 8'h5A;
    dc_in = 1'b1;
    start[0] = 1'b1;
    r0 = rises[0];
    d0 = dones[0];
    wait_cnt = 0;
    while (rises[0] - r0 < 3 && wait_cnt < 200) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("third_rise_seen", 32'(rises[0] - r0), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cs_n", 32'(csn[0]),  32'd1);
    chk("rst_sclk", 32'(sclk[0]), 32'd0);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_dc",   32'(odc[0]),  32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("rst_no_done", 32'(dones[0] - d0), 32'd0);
    chk("rst_no_more_rises", 32'(rises[0] - r0), 32'd3);

    v81 = '{0, 8'h81, 1'b1, 1'b0, 0, 8'h81, 72, 80};
    xfer(v81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
